// File: rtl/fft_stage_sequencer.sv
// Stage and butterfly sequencer for an in-place radix-2 DIF FFT engine.
// Issues operand addresses and twiddle indices per butterfly, with a drain gap between stages.
module fft_stage_sequencer #(
  parameter  int N        = 16,
  parameter  int PIPE_LAT = 3,
  localparam int STAGES   = $clog2(N),
  localparam int ADDR_W   = STAGES
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              start_i,
  input  logic              bfly_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bfly_valid_o,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [ADDR_W-2:0] tw_idx_o,
  output logic [STAGES-1:0] stage_onehot_o,
  output logic              shift_en_o
);

  localparam int KW = ADDR_W - 1;
  localparam int SW = $clog2(STAGES);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     stage, stage_n;
  logic [KW-1:0]     k, k_n;
  logic [DW-1:0]     drain_cnt, drain_n;
  logic [STAGES-1:0] onehot, onehot_n;

  logic              last_drain;
  logic              last_stage;

  logic [SW:0]       s_p1;
  logic [ADDR_W-1:0] low_mask;
  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-2:0] tw;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      drain_cnt <= '0;
      onehot    <= '0;
    end else begin
      state     <= state_n;
      stage     <= stage_n;
      k         <= k_n;
      drain_cnt <= drain_n;
      onehot    <= onehot_n;
    end
  end

  assign last_drain = (state == DRAIN) && (drain_cnt == DW'(PIPE_LAT - 1));
  assign last_stage = (stage == SW'(STAGES - 1));

  always_comb begin
    state_n  = state;
    stage_n  = stage;
    k_n      = k;
    drain_n  = drain_cnt;
    onehot_n = onehot;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n  = RUN;
          stage_n  = '0;
          k_n      = '0;
          onehot_n = STAGES'(1);
        end
      end
      RUN: begin
        if (bfly_ready_i) begin
          if (k == KW'(N / 2 - 1)) begin
            k_n     = '0;
            drain_n = '0;
            state_n = DRAIN;
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (last_drain) begin
          drain_n = '0;
          if (last_stage) begin
            state_n = DONE;
          end else begin
            stage_n  = stage + SW'(1);
            onehot_n = onehot << 1;
            state_n  = RUN;
          end
        end else begin
          drain_n = drain_cnt + DW'(1);
        end
      end
      DONE: begin
        state_n  = IDLE;
        stage_n  = '0;
        onehot_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Address generation: half = N >> (s+1), so the low (STAGES-1-s) bits of k select the
  // position inside a group and the remaining bits select the group.
  always_comb begin
    s_p1     = {1'b0, stage} + (SW + 1)'(1);
    low_mask = {ADDR_W{1'b1}} >> s_p1;
    k_ext    = {1'b0, k};
    pos      = k_ext & low_mask;
    addr_a   = ((k_ext & ~low_mask) << 1) | pos;
    addr_b   = addr_a + (low_mask + ADDR_W'(1));
    tw       = pos[ADDR_W-2:0] << stage;
  end

  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);
  assign bfly_valid_o   = (state == RUN);
  assign shift_en_o     = last_drain && !last_stage;
  assign stage_onehot_o = onehot;
  assign addr_a_o       = (state == RUN) ? addr_a : '0;
  assign addr_b_o       = (state == RUN) ? addr_b : '0;
  assign tw_idx_o       = (state == RUN) ? tw : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (N=16, PIPE_LAT=3).
module tb_fft_stage_sequencer;

  localparam int N  = 16;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       arstn;
  logic       start_i;
  logic       bfly_ready_i;
  logic       busy_o;
  logic       done_o;
  logic       bfly_valid_o;
  logic [3:0] addr_a_o;
  logic [3:0] addr_b_o;
  logic [2:0] tw_idx_o;
  logic [3:0] stage_onehot_o;
  logic       shift_en_o;

  fft_stage_sequencer #(.N(N), .PIPE_LAT(PL)) dut (
    .clk            (clk),
    .arstn          (arstn),
    .start_i        (start_i),
    .bfly_ready_i   (bfly_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .bfly_valid_o   (bfly_valid_o),
    .addr_a_o       (addr_a_o),
    .addr_b_o       (addr_b_o),
    .tw_idx_o       (tw_idx_o),
    .stage_onehot_o (stage_onehot_o),
    .shift_en_o     (shift_en_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [3:0] oh;
  } bfly_t;

  bfly_t bq[$];
  int    sq[$];
  int    dq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    t0 = 0;
  bfly_t me;
  int    mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bfly_t mk(input int s, input int k, input int c);
    bfly_t r;
    int half, grp, pos, a;
    half = N >> (s + 1);
    grp  = k / half;
    pos  = k % half;
    a    = grp * 2 * half + pos;
    r.c  = c;
    r.a  = 4'(a);
    r.b  = 4'(a + half);
    r.tw = 3'((pos << s) % (N / 2));
    r.oh = 4'(1 << s);
    return r;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({busy_o, done_o, bfly_valid_o, addr_a_o, addr_b_o, tw_idx_o,
                stage_onehot_o, shift_en_o});
  endfunction

  // Monitor: pops the expected response whenever the DUT presents one.
  always @(negedge clk) begin
    if (arstn === 1'b1) begin
      mc = cyc - t0 + 1;
      if (bfly_valid_o && bfly_ready_i) begin
        if (bq.size() == 0) chk("bfly_extra", 32'(bq.size()), 32'd1);
        else begin
          me = bq.pop_front();
          chk("bfly_cycle", 32'(mc), 32'(me.c));
          chk("bfly_fields", 32'({addr_a_o, addr_b_o, tw_idx_o, stage_onehot_o}),
              32'({me.a, me.b, me.tw, me.oh}));
        end
      end
      if (shift_en_o) begin
        if (sq.size() == 0) chk("shift_extra", 32'(sq.size()), 32'd1);
        else chk("shift_cycle", 32'(mc), 32'(sq.pop_front()));
      end
      if (done_o) begin
        if (dq.size() == 0) chk("done_extra", 32'(dq.size()), 32'd1);
        else chk("done_cycle", 32'(mc), 32'(dq.pop_front()));
      end
    end
  end

  task automatic run(input bit stall, input bit extra, input int abort_at);
    int done_c;
    int c;
    bit spot;
    done_c = 45 + (stall ? 5 : 0);
    spot   = !stall && !extra && (abort_at == 0);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        c = 1 + s * (N / 2 + PL) + k;
        if (stall && (s > 1 || (s == 1 && k >= 2))) c += 5;
        bq.push_back(mk(s, k, c));
      end
      if (s < 3) sq.push_back((s + 1) * (N / 2 + PL) + ((stall && s >= 1) ? 5 : 0));
    end
    dq.push_back(done_c);

    start_i = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start_i = 1'b0;
    for (int r = 1; r <= done_c + 2; r++) begin
      if (r == abort_at) begin
        arstn = 1'b0;
        #1;
        chk("abort_outputs", all_outs(), 32'd0);
        bq.delete(); sq.delete(); dq.delete();
        @(posedge clk); #1;
        chk("abort_hold", all_outs(), 32'd0);
        arstn = 1'b1;
        return;
      end
      bfly_ready_i = !(stall && r >= 14 && r <= 18);
      start_i = extra && (r == 5 || r == done_c);
      chk("busy", 32'(busy_o), 32'(r <= done_c));
      if (r == done_c + 1) chk("onehot_idle", 32'(stage_onehot_o), 32'd0);
      if (stall && r >= 14 && r <= 18)
        chk("stall_hold", 32'({bfly_valid_o, addr_a_o, addr_b_o, tw_idx_o}),
            32'({1'b1, 4'd2, 4'd6, 3'd4}));
      if (spot) begin
        case (r)
          1:  chk("spot_s0k0", 32'({addr_a_o, addr_b_o, tw_idx_o}), 32'({4'd0, 4'd8, 3'd0}));
          8:  chk("spot_s0k7", 32'({addr_a_o, addr_b_o, tw_idx_o}), 32'({4'd7, 4'd15, 3'd7}));
          17: chk("spot_s1k5", 32'({addr_a_o, addr_b_o, tw_idx_o}), 32'({4'd9, 4'd13, 3'd2}));
          37: chk("spot_s3k3", 32'({addr_a_o, addr_b_o, tw_idx_o}), 32'({4'd6, 4'd7, 3'd0}));
          default: ;
        endcase
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    bfly_ready_i = 1'b1;
    chk("bfly_missing", 32'(bq.size()), 32'd0);
    chk("shift_missing", 32'(sq.size()), 32'd0);
    chk("done_missing", 32'(dq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arstn = 1'b0;
    start_i = 1'b0;
    bfly_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    arstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", all_outs(), 32'd0);
    end

    run(1'b0, 1'b0, 0);
    run(1'b1, 1'b0, 0);
    run(1'b0, 1'b1, 0);
    run(1'b0, 1'b0, 20);
    run(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
